dpram_fifo_ctrl: RTL and testbench

- Controller that sequences a single-clock simple dual-port RAM (separate read/write ports, asynchronous read) as a first-word-fall-through FIFO.
- Provides valid/ready streaming on the push and pop sides, occupancy count, almost-full and synchronous flush.
- Drives the RAM's raddr/waddr/we/din and returns its dout as pop data.
- Used as the staging buffer between the bus interface and the crypto cores.

---
 rtl/dpram_fifo_ctrl_pkg.sv | 14 +
 rtl/dpram_fifo.sv | 63 ++++++
 rtl/dpram_ram.sv | 34 +++
 rtl/dpram_fifo_ctrl.sv | 81 ++++++++
 tb/tb_dpram_fifo_ctrl.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/dpram_fifo_ctrl_pkg.sv
// Shared definitions for the dual-port-RAM FIFO: pointer width helper and
// the streaming handshake convention used on both FIFO sides.
package dpram_fifo_ctrl_pkg;

    // Handshake: a word moves on a rising edge where valid && ready are both 1.
    // Valid never depends on ready, and ready never depends on valid.
    function automatic int fifo_ptr_w(input int addr_width);
        return addr_width + 1;
    endfunction

    localparam int DEFAULT_ADDR_WIDTH = 4;
    localparam int DEFAULT_DATA_WIDTH = 32;

endpackage

// File: rtl/dpram_fifo.sv
// FIFO wrapper: controller plus the simple dual-port RAM, bypass disabled
// so a pushed word only appears after the write edge.
module dpram_fifo
    import dpram_fifo_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int AFULL_THRESH = 2 ** ADDR_WIDTH - 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  almost_full
);

    logic [ADDR_WIDTH-1:0] ram_waddr, ram_raddr;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_din, ram_dout;

    dpram_fifo_ctrl #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .AFULL_THRESH(AFULL_THRESH)
    ) u_ctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .count      (count),
        .almost_full(almost_full),
        .ram_waddr  (ram_waddr),
        .ram_we     (ram_we),
        .ram_din    (ram_din),
        .ram_raddr  (ram_raddr),
        .ram_dout   (ram_dout)
    );

    dpram_ram #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .DATA_WIDTH   (DATA_WIDTH),
        .ENABLE_BYPASS(1'b0)
    ) u_ram (
        .clk    (clk),
        .we_i   (ram_we),
        .waddr_i(ram_waddr),
        .din_i  (ram_din),
        .raddr_i(ram_raddr),
        .dout_o (ram_dout)
    );

endmodule

// File: rtl/dpram_ram.sv
// Simple dual-port RAM: synchronous write port, asynchronous read port,
// optional write-to-read bypass.
module dpram_ram #(
    parameter int ADDR_WIDTH    = 4,
    parameter int DATA_WIDTH    = 32,
    parameter bit ENABLE_BYPASS = 1'b0
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] dout_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= din_i;
        end
    end

    generate
        if (ENABLE_BYPASS) begin : g_bypass
            assign dout_o = (we_i && (waddr_i == raddr_i)) ? din_i : mem_q[raddr_i];
        end else begin : g_no_bypass
            assign dout_o = mem_q[raddr_i];
        end
    endgenerate

endmodule

// File: rtl/dpram_fifo_ctrl.sv
// First-word-fall-through FIFO controller driving an external simple
// dual-port RAM with asynchronous read.
module dpram_fifo_ctrl
    import dpram_fifo_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int AFULL_THRESH = 2 ** ADDR_WIDTH - 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  almost_full,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    localparam int PW = fifo_ptr_w(ADDR_WIDTH);
    localparam logic [PW-1:0] DEPTH_P = PW'(2 ** ADDR_WIDTH);
    localparam logic [PW-1:0] AFULL_P = PW'(AFULL_THRESH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          empty, full, push, pop;

    // MSB is the wrap flag: equal low bits with differing MSBs means full.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                   (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);

    assign s_ready = !full && !flush;
    assign m_valid = !empty && !flush;
    assign push    = s_valid && s_ready;
    assign pop     = m_valid && m_ready;

    assign count       = wr_ptr_q - rd_ptr_q;
    assign almost_full = (count >= AFULL_P);

    assign ram_we    = push;
    assign ram_waddr = wr_ptr_q[ADDR_WIDTH-1:0];
    assign ram_din   = s_data;
    assign ram_raddr = rd_ptr_q[ADDR_WIDTH-1:0];
    assign m_data    = ram_dout;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    a_no_write_when_full: assert property (@(posedge clk) disable iff (!rst_n) !(ram_we && full));
    a_count_bounded:      assert property (@(posedge clk) disable iff (!rst_n) count <= DEPTH_P);
    a_no_pop_when_empty:  assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Self-checking bench for the dual-port-RAM FIFO controller and its wrapper,
// compared against a queue-based FIFO model.
module tb_dpram_fifo_ctrl;

    localparam int AW    = 2;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int AFULL = 2;

    typedef struct {
        logic          s_ready;
        logic          m_valid;
        logic [AW:0]   count;
        logic          af;
        logic          ram_we;
        logic [AW-1:0] waddr;
        logic [DW-1:0] din;
    } status_t;

    // Clock/reset block
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n   = 1'b1;
    logic          flush   = 1'b0;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data  = '0;
    logic          m_ready = 1'b0;

    logic          s_ready, m_valid, almost_full, ram_we;
    logic [DW-1:0] m_data, ram_din, ram_dout;
    logic [AW:0]   count;
    logic [AW-1:0] ram_waddr, ram_raddr;

    logic          w_s_ready, w_m_valid, w_af;
    logic [DW-1:0] w_m_data;
    logic [AW:0]   w_count;

    dpram_fifo_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AFULL_THRESH(AFULL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .count      (count),
        .almost_full(almost_full),
        .ram_waddr  (ram_waddr),
        .ram_we     (ram_we),
        .ram_din    (ram_din),
        .ram_raddr  (ram_raddr),
        .ram_dout   (ram_dout)
    );

    dpram_ram #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ENABLE_BYPASS(1'b0)
    ) u_ram (
        .clk    (clk),
        .we_i   (ram_we),
        .waddr_i(ram_waddr),
        .din_i  (ram_din),
        .raddr_i(ram_raddr),
        .dout_o (ram_dout)
    );

    dpram_fifo #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AFULL_THRESH(AFULL)
    ) u_wrap (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .s_valid    (s_valid),
        .s_ready    (w_s_ready),
        .s_data     (s_data),
        .m_valid    (w_m_valid),
        .m_ready    (m_ready),
        .m_data     (w_m_data),
        .count      (w_count),
        .almost_full(w_af)
    );

    // Scoreboard state: exp_q holds the words the FIFO should contain, oldest first
    logic [DW-1:0] exp_q[$];
    status_t       st_q[$];
    int            wr_idx = 0;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Driver: one call = one clock cycle; expectations come from the model queue
    task automatic drive(input logic sv, input logic [DW-1:0] sd, input logic mr,
                         input logic fl, input logic rst);
        status_t e;
        int n;
        rst_n   = !rst;
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        flush   = fl;
        if (rst) begin
            exp_q.delete();
            wr_idx = 0;
        end
        n         = exp_q.size();
        e.s_ready = (n < DEPTH) && !fl;
        e.m_valid = (n > 0) && !fl;
        e.count   = (AW+1)'(n);
        e.af      = (n >= AFULL);
        e.ram_we  = sv && e.s_ready;
        e.waddr   = AW'(wr_idx);
        e.din     = sd;
        st_q.push_back(e);
        if (e.ram_we) begin
            exp_q.push_back(sd);
            wr_idx++;
        end
        if (fl) begin
            exp_q.delete();
            wr_idx = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic mr);
        drive(1'b0, '0, mr, 1'b0, 1'b0);
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        drive(1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: compare status every cycle, pop the scoreboard on each DUT pop
    always @(negedge clk) begin
        status_t e;
        logic [DW-1:0] d;
        if (st_q.size() > 0) begin
            e = st_q.pop_front();
            chk("s_ready",     {31'b0, s_ready},     {31'b0, e.s_ready});
            chk("m_valid",     {31'b0, m_valid},     {31'b0, e.m_valid});
            chk("count",       DW'(count),           DW'(e.count));
            chk("almost_full", {31'b0, almost_full}, {31'b0, e.af});
            chk("ram_we",      {31'b0, ram_we},      {31'b0, e.ram_we});
            chk("wrap_s_ready", {31'b0, w_s_ready},  {31'b0, e.s_ready});
            chk("wrap_m_valid", {31'b0, w_m_valid},  {31'b0, e.m_valid});
            chk("wrap_count",  DW'(w_count),         DW'(e.count));
            chk("wrap_afull",  {31'b0, w_af},        {31'b0, e.af});
            if (e.ram_we) begin
                chk("ram_waddr", DW'(ram_waddr), DW'(e.waddr));
                chk("ram_din",   ram_din,        e.din);
            end
        end
        if (rst_n && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_underflow: got pop with m_data %0h expected no pop at %0t", m_data, $time);
            end else begin
                d = exp_q.pop_front();
                chk("m_data",      m_data,   d);
                chk("wrap_m_data", w_m_data, d);
            end
        end
    end

    // Stimulus
    initial begin
        @(posedge clk);
        #1;
        // Reset then idle
        for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) idle(1'b1);

        // Fill/drain, including a rejected push while full
        for (int i = 0; i < 4; i++) push_word(32'hA0 + i);
        push_word(32'hEE);
        for (int i = 0; i < 5; i++) idle(1'b1);

        // Fall-through latency from empty
        drive(1'b1, 32'h55, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b0);

        // Simultaneous push/pop at count=2, pointers wrap several times
        push_word(32'hB0);
        push_word(32'hB1);
        for (int i = 0; i < 20; i++) drive(1'b1, $urandom, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Full with pop: pop only, push accepted next cycle
        for (int i = 0; i < 4; i++) push_word(32'hA0 + i);
        drive(1'b1, 32'hC0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 32'hC0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) idle(1'b1);

        // Flush with almost_full set and a push pending
        for (int i = 0; i < 3; i++) push_word(32'hD0 + i);
        drive(1'b1, 32'hDD, 1'b0, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b0);

        // Randomized traffic with occasional flush and one mid-run reset
        for (int i = 0; i < 400; i++) begin
            if (i == 200 || i == 201) begin
                drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
            end else begin
                drive($urandom_range(0, 3) != 0, $urandom,
                      (i % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                      $urandom_range(0, 39) == 0, 1'b0);
            end
        end
        for (int i = 0; i < 6; i++) idle(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
